joystick_conditioner: RTL and testbench

JOYSTICK_CONDITIONER -- requirements
Module: joystick_conditioner

---
 rtl/joystick_conditioner.sv | 104 ++++++++++
 tb/tb_joystick_conditioner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_conditioner.sv
// Joystick conditioner: synchronizes, debounces and SOCD-filters two
// active-low 5-bit joystick ports into registered active-high outputs.
module joystick_conditioner #(
    parameter int PRESCALE       = 108000,
    parameter int DEBOUNCE_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] fa_n,
    input  logic [4:0] fb_n,
    input  logic       socd_mask,
    output logic [4:0] joy1,
    output logic [4:0] joy2,
    output logic       changed
);

    localparam int PW = $clog2(PRESCALE);
    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE_TICKS - 1);

    logic [9:0]    sync1;
    logic [9:0]    sync2;
    logic [9:0]    synced;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [9:0]    stable;
    logic [CW-1:0] db_cnt [10];
    logic [4:0]    nxt1;
    logic [4:0]    nxt2;

    // Kill both halves of an opposing pair when masking is enabled.
    function automatic logic [4:0] socd(input logic [4:0] s, input logic en);
        logic [4:0] r;
        r = s;
        if (en && s[0] && s[1]) r[1:0] = 2'b00;
        if (en && s[2] && s[3]) r[3:2] = 2'b00;
        return r;
    endfunction

    assign synced = ~sync2;
    assign tick   = (pre_cnt == PLAST);
    assign nxt1   = socd(stable[4:0], socd_mask);
    assign nxt2   = socd(stable[9:5], socd_mask);

    // Two-flop synchronizer; idle (released) pins read as 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {fb_n, fa_n};
            sync2 <= sync1;
        end
    end

    // Free-running prescaler producing a one-cycle debounce tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Per-bit debounce: any cycle matching the stable level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < 10; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (synced[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick) begin
                    if (db_cnt[i] == CLAST) begin
                        stable[i] <= synced[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Output register with a single change pulse per update.
    always_ff @(posedge clk) begin
        if (reset) begin
            joy1    <= '0;
            joy2    <= '0;
            changed <= 1'b0;
        end else begin
            joy1    <= nxt1;
            joy2    <= nxt2;
            changed <= ({nxt2, nxt1} != {joy2, joy1});
        end
    end

endmodule

// File: tb/tb_joystick_conditioner.sv
// Testbench for joystick_conditioner: directed scenarios plus a
// cycle-by-cycle reference model of the debounce behaviour.
module tb_joystick_conditioner;

    localparam int PRESCALE = 4;
    localparam int DB       = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] fa_n;
    logic [4:0] fb_n;
    logic       socd_mask;
    logic [4:0] joy1;
    logic [4:0] joy2;
    logic       changed;

    int errors  = 0;
    int checks  = 0;
    int chg_cnt = 0;
    int c0;
    bit sb_on   = 1'b0;

    joystick_conditioner #(
        .PRESCALE      (PRESCALE),
        .DEBOUNCE_TICKS(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fa_n     (fa_n),
        .fb_n     (fb_n),
        .socd_mask(socd_mask),
        .joy1     (joy1),
        .joy2     (joy2),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] mask5(input logic [4:0] s, input logic en);
        logic ud;
        logic lr;
        ud = en & s[0] & s[1];
        lr = en & s[2] & s[3];
        return {s[4], s[3] & ~lr, s[2] & ~lr, s[1] & ~ud, s[0] & ~ud};
    endfunction

    // Reference model, advanced on every rising edge.
    logic [9:0] m_s1;
    logic [9:0] m_s2;
    logic [9:0] m_stab;
    int         m_pre;
    int         m_cnt [10];
    logic [4:0] m_j1;
    logic [4:0] m_j2;
    logic       m_chg;

    always @(posedge clk) begin : model
        logic [9:0] syn;
        logic       tk;
        logic [4:0] n1;
        logic [4:0] n2;
        if (reset) begin
            m_s1   = '1;
            m_s2   = '1;
            m_stab = '0;
            m_pre  = 0;
            for (int i = 0; i < 10; i++) m_cnt[i] = 0;
            m_j1   = '0;
            m_j2   = '0;
            m_chg  = 1'b0;
        end else begin
            n1    = mask5(m_stab[4:0], socd_mask);
            n2    = mask5(m_stab[9:5], socd_mask);
            m_chg = (n1 != m_j1) || (n2 != m_j2);
            m_j1  = n1;
            m_j2  = n2;
            tk    = (m_pre == PRESCALE - 1);
            syn   = ~m_s2;
            for (int i = 0; i < 10; i++) begin
                if (syn[i] == m_stab[i]) begin
                    m_cnt[i] = 0;
                end else if (tk) begin
                    if (m_cnt[i] == DB - 1) begin
                        m_stab[i] = syn[i];
                        m_cnt[i]  = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            m_pre = tk ? 0 : m_pre + 1;
            m_s2  = m_s1;
            m_s1  = {fb_n, fa_n};
        end
    end

    always @(posedge clk) begin
        if (changed === 1'b1) chg_cnt++;
    end

    always @(negedge clk) begin
        if (sb_on) begin
            check("sb_joy1", joy1, m_j1);
            check("sb_joy2", joy2, m_j2);
            check("sb_chg", changed, m_chg);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        fa_n      = '1;
        fb_n      = '1;
        socd_mask = 1'b0;
        cyc(3);
        sb_on = 1'b1;
        check("rst_joy1", joy1, 0);
        check("rst_joy2", joy2, 0);
        check("rst_chg", changed, 0);

        // Up pressed and held: accepted on the 3rd tick, edge 12.
        fa_n  = 5'b11110;
        reset = 1'b0;
        c0    = chg_cnt;
        cyc(12);
        check("up_pre", joy1, 0);
        cyc(1);
        check("up_joy1", joy1, 5'b00001);
        check("up_chg", changed, 1);
        check("up_joy2", joy2, 0);
        cyc(1);
        check("up_chg_end", changed, 0);
        cyc(1);
        check("up_pulses", chg_cnt - c0, 1);

        // Reset mid-debounce discards two accumulated ticks.
        reset = 1'b1;
        cyc(2);
        check("r29_rst", joy1, 0);
        reset = 1'b0;
        cyc(9);
        check("r29_mid", joy1, 0);
        reset = 1'b1;
        cyc(2);
        check("r29_rst2", joy1, 0);
        reset = 1'b0;
        cyc(12);
        check("r29_pre", joy1, 0);
        cyc(1);
        check("r29_joy1", joy1, 5'b00001);

        // Short fire pulses on port B never get accepted.
        reset = 1'b1;
        fa_n  = '1;
        cyc(2);
        reset = 1'b0;
        c0    = chg_cnt;
        for (int r = 0; r < 4; r++) begin
            fb_n = 5'b01111;
            cyc(5);
            fb_n = 5'b11111;
            cyc(5);
        end
        cyc(16);
        check("glitch_joy2", joy2, 0);
        check("glitch_pulses", chg_cnt - c0, 0);

        // SOCD: up+down held with masking, then masking dropped.
        reset     = 1'b1;
        cyc(2);
        socd_mask = 1'b1;
        fa_n      = 5'b11100;
        reset     = 1'b0;
        cyc(20);
        check("socd_on", joy1, 0);
        c0        = chg_cnt;
        socd_mask = 1'b0;
        cyc(1);
        check("socd_off", joy1, 5'b00011);
        check("socd_chg", changed, 1);
        cyc(1);
        check("socd_chg_end", changed, 0);
        cyc(1);
        check("socd_pulses", chg_cnt - c0, 1);

        // Simultaneous release on both ports clears in one cycle.
        reset = 1'b1;
        cyc(2);
        fa_n  = 5'b01111;
        fb_n  = 5'b10111;
        reset = 1'b0;
        cyc(16);
        check("both_joy1", joy1, 5'b10000);
        check("both_joy2", joy2, 5'b01000);
        c0   = chg_cnt;
        fa_n = '1;
        fb_n = '1;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (joy1 != 5'b10000) break;
        end
        check("rel_joy1", joy1, 0);
        check("rel_joy2", joy2, 0);
        check("rel_chg", changed, 1);
        cyc(2);
        check("rel_pulses", chg_cnt - c0, 1);

        // Random noise bursts mixed with long stable windows.
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 4) == 0) socd_mask = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 6)) begin
                    fa_n = 5'($urandom);
                    fb_n = 5'($urandom);
                    cyc(1);
                end
            end else begin
                fa_n = 5'($urandom);
                fb_n = 5'($urandom);
                cyc(14);
            end
        end
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
